// File: rtl/mr_chips_pkg.sv
// Shared types for the mr_chips execution-trace path.
// A trace entry is one {pc, alu} sample pair; the stream sends it as two 16-bit beats.
package mr_chips_pkg;

  localparam int TRACE_W = 32;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] alu;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND_PC,
    SEND_ALU
  } trace_state_t;

endpackage

// File: rtl/mr_chips_trace_fifo.sv
// Synchronous FIFO with a combinational peek of the head or the entry behind it.
// A push while full is accepted only when a pop happens on the same edge.
module mr_chips_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     peek_next,
  output logic [WIDTH-1:0]         peek,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW-1:0]    peek_idx;
  logic             do_push;
  logic             do_pop;

  assign level    = wr_ptr_reg - rd_ptr_reg;
  assign full     = (level == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign peek_idx = rd_ptr_reg[AW-1:0] + AW'(peek_next);
  assign peek     = mem[peek_idx];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mr_chips_trace.sv
// Execution-trace capture: samples {pc, alu} whenever the PC changes while armed,
// buffers samples and streams each one as a PC beat followed by an ALU beat.
module mr_chips_trace
  import mr_chips_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic [DATA_W-1:0]       pc_in,
  input  logic [DATA_W-1:0]       alu_in,
  output logic [DATA_W-1:0]       tr_data,
  output logic                    tr_valid,
  input  logic                    tr_ready,
  output logic                    tr_last,
  output logic                    overflow,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int LW = $clog2(DEPTH) + 1;

  trace_state_t      state_reg, state_next;
  logic [DATA_W-1:0] tr_data_reg, tr_data_next;
  logic              tr_valid_reg, tr_valid_next;
  logic              tr_last_reg, tr_last_next;
  logic [DATA_W-1:0] prev_pc_reg;
  logic              first_reg;
  logic              arm_prev_reg;
  logic              overflow_reg;
  logic [CNT_W-1:0]  drop_cnt_reg;

  trace_entry_t      wr_entry;
  trace_entry_t      peek_entry;
  logic              capture;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  assign capture  = arm && (first_reg || (pc_in != prev_pc_reg));
  assign pop      = (state_reg == SEND_ALU) && tr_valid_reg && tr_ready;
  assign drop     = capture && fifo_full && !pop;
  assign wr_entry = '{pc: pc_in, alu: alu_in};

  // In SEND_ALU the peek looks one entry ahead so the next PC beat follows without a bubble.
  mr_chips_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .wdata     (wr_entry),
    .pop       (pop),
    .peek_next (state_reg == SEND_ALU),
    .peek      (peek_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pc_reg  <= '0;
      first_reg    <= 1'b1;
      arm_prev_reg <= 1'b0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      prev_pc_reg  <= pc_in;
      first_reg    <= !arm;
      arm_prev_reg <= arm;
      // A fresh arm starts new statistics, counting only a drop on that same edge.
      if (arm && !arm_prev_reg) begin
        overflow_reg <= drop;
        drop_cnt_reg <= drop ? CNT_W'(1) : '0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      tr_data_reg  <= '0;
      tr_valid_reg <= 1'b0;
      tr_last_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tr_data_reg  <= tr_data_next;
      tr_valid_reg <= tr_valid_next;
      tr_last_reg  <= tr_last_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tr_data_next  = tr_data_reg;
    tr_valid_next = tr_valid_reg;
    tr_last_next  = tr_last_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          tr_data_next  = peek_entry.pc;
          tr_valid_next = 1'b1;
          tr_last_next  = 1'b0;
          state_next    = SEND_PC;
        end
      end
      SEND_PC: begin
        if (tr_valid_reg && tr_ready) begin
          tr_data_next = peek_entry.alu;
          tr_last_next = 1'b1;
          state_next   = SEND_ALU;
        end
      end
      SEND_ALU: begin
        if (tr_valid_reg && tr_ready) begin
          if (level > LW'(1)) begin
            tr_data_next = peek_entry.pc;
            tr_last_next = 1'b0;
            state_next   = SEND_PC;
          end else begin
            tr_valid_next = 1'b0;
            tr_last_next  = 1'b0;
            state_next    = IDLE;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        tr_valid_next = 1'b0;
        tr_last_next  = 1'b0;
      end
    endcase
  end

  assign tr_data  = tr_data_reg;
  assign tr_valid = tr_valid_reg;
  assign tr_last  = tr_last_reg;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_mr_chips_trace.sv
// Self-checking bench for mr_chips_trace: a queue-based reference model checks every
// beat, level and the drop statistics; scenario tasks add targeted checks.
module tb_mr_chips_trace;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              arm = 1'b1;
  logic [DATA_W-1:0] pc_in = '0;
  logic [DATA_W-1:0] alu_in = '0;
  logic              tr_ready = 1'b1;
  logic [DATA_W-1:0] tr_data;
  logic              tr_valid;
  logic              tr_last;
  logic              overflow;
  logic [CNT_W-1:0]  drop_cnt;
  logic [3:0]        level;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] alu;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] seen[$];
  logic [15:0] m_prev_pc;
  bit          m_first, m_arm_prev, m_ov, m_phase, stall;
  int          m_drops;
  logic [15:0] stall_data;
  logic        stall_last;

  mr_chips_trace #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .arm(arm), .pc_in(pc_in), .alu_in(alu_in),
    .tr_data(tr_data), .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_last(tr_last),
    .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
  );

  always #5 clk = ~clk;

  // Reference model: at each falling edge, check state after the last rising edge,
  // then apply the rules for the coming rising edge using the now-stable inputs.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mq.delete();
      m_prev_pc = '0; m_first = 1; m_arm_prev = 0; m_ov = 0; m_drops = 0;
      m_phase = 0; stall = 0;
    end else begin
      int  exp_level;
      bit  xfer, pop, cap;
      exp_level = mq.size();
      checks++;
      if (level !== exp_level[3:0] || overflow !== m_ov || drop_cnt !== m_drops[7:0]) begin
        errors++;
        $display("FAIL model_state: level=%0d ovf=%b drops=%0d, required level=%0d ovf=%b drops=%0d",
                 level, overflow, drop_cnt, exp_level, m_ov, m_drops);
      end
      if (stall) begin
        checks++;
        if (tr_valid !== 1'b1 || tr_data !== stall_data || tr_last !== stall_last) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   tr_valid, tr_data, tr_last, stall_data, stall_last);
        end
      end
      xfer = (tr_valid === 1'b1) && (tr_ready === 1'b1);
      pop  = 0;
      if (tr_valid === 1'b1 && mq.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_beat: data=%h valid with no entry expected", tr_data);
      end else if (xfer) begin
        logic [15:0] exp_d;
        exp_d = m_phase ? mq[0].alu : mq[0].pc;
        checks++;
        if (tr_data !== exp_d || tr_last !== m_phase) begin
          errors++;
          $display("FAIL beat: data=%h last=%b, required data=%h last=%b", tr_data, tr_last, exp_d, m_phase);
        end
        $display("beat data=%h last=%b", tr_data, tr_last);
        seen.push_back(tr_data);
        if (m_phase) begin
          void'(mq.pop_front());
          pop = 1;
        end
        m_phase = !m_phase;
      end
      stall      = (tr_valid === 1'b1) && (tr_ready !== 1'b1);
      stall_data = tr_data;
      stall_last = tr_last;
      cap = arm && (m_first || pc_in != m_prev_pc);
      if (arm && !m_arm_prev) begin
        m_ov = 0; m_drops = 0;
      end
      if (cap) begin
        if (mq.size() < DEPTH) begin
          mq.push_back('{pc: pc_in, alu: alu_in});
        end else begin
          m_ov = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (pop && cap) begin end
      m_prev_pc  = pc_in;
      m_first    = !arm;
      m_arm_prev = arm;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done;
    done = 0;
    for (int n = 0; n < max_cycles; n++) begin
      if (mq.size() == 0 && tr_valid === 1'b0) begin
        done = 1;
        break;
      end
      step();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: level=%0d valid=%b after %0d cycles, required empty", level, tr_valid, max_cycles);
    end
  endtask

  task automatic test_reset();
    logic [15:0] exp1 [6];
    exp1 = '{16'h0000, 16'h0010, 16'h0001, 16'h0011, 16'h0002, 16'h0012};
    arm = 1; tr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      pc_in = pc_in + 16'h1111;
      @(negedge clk);
      checks++;
      if (tr_valid !== 0 || tr_last !== 0 || tr_data !== 0 || overflow !== 0 || drop_cnt !== 0 || level !== 0) begin
        errors++;
        $display("FAIL reset_outputs: valid=%b last=%b data=%h ovf=%b drops=%0d level=%0d, required all 0",
                 tr_valid, tr_last, tr_data, overflow, drop_cnt, level);
      end
    end
    step();
    reset = 1; pc_in = 16'h0000; alu_in = 16'h0010;
    seen.delete();
    step();
    pc_in = 16'h0001; alu_in = 16'h0011;
    @(negedge clk);
    checks++;
    if (tr_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge_e: valid=%b, required 0", tr_valid);
    end
    step();
    pc_in = 16'h0002; alu_in = 16'h0012;
    @(negedge clk);
    checks++;
    if (tr_valid !== 1'b1 || tr_data !== 16'h0000) begin
      errors++;
      $display("FAIL latency_edge_e1: valid=%b data=%h, required valid=1 data=0000", tr_valid, tr_data);
    end
    step();
    wait_drain(50);
    checks++;
    if (seen.size() != 6) begin
      errors++;
      $display("FAIL basic_count: beats=%0d, required 6", seen.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seen[i] !== exp1[i]) begin
          errors++;
          $display("FAIL basic_beat%0d: data=%h, required %h", i, seen[i], exp1[i]);
        end
      end
    end
  endtask

  task automatic test_hold_pc();
    logic [15:0] a0;
    seen.delete();
    step();
    pc_in = 16'h0005; a0 = 16'($urandom); alu_in = a0;
    for (int i = 0; i < 3; i++) begin
      step();
      alu_in = 16'($urandom);
    end
    step();
    wait_drain(50);
    checks++;
    if (seen.size() != 2 || seen[0] !== 16'h0005 || seen[1] !== a0) begin
      errors++;
      $display("FAIL hold_pc: beats=%0d first=%h second=%h, required 2 beats 0005 %h",
               seen.size(), seen.size() > 0 ? seen[0] : 16'hxxxx, seen.size() > 1 ? seen[1] : 16'hxxxx, a0);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] pcs [12];
    logic [15:0] alus [12];
    seen.delete();
    tr_ready = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      pcs[i] = 16'h0100 + 16'(i); alus[i] = 16'($urandom);
      pc_in = pcs[i]; alu_in = alus[i];
    end
    step();
    @(negedge clk);
    checks++;
    if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd4) begin
      errors++;
      $display("FAIL overflow_counts: level=%0d ovf=%b drops=%0d, required 8 1 4", level, overflow, drop_cnt);
    end
    step();
    tr_ready = 1;
    wait_drain(100);
    checks++;
    if (seen.size() != 16) begin
      errors++;
      $display("FAIL overflow_drain_count: beats=%0d, required 16", seen.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (seen[2*i] !== pcs[i] || seen[2*i+1] !== alus[i]) begin
          errors++;
          $display("FAIL overflow_entry%0d: %h %h, required %h %h", i, seen[2*i], seen[2*i+1], pcs[i], alus[i]);
        end
      end
    end
  endtask

  task automatic test_full_pushpop();
    int pushes;
    pushes = 0;
    seen.delete();
    tr_ready = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      pc_in = 16'h0200 + 16'(i); alu_in = 16'($urandom);
    end
    step();
    tr_ready = 1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (tr_valid === 1'b1 && tr_last === 1'b1) begin
        pc_in = 16'h0280 + 16'(pushes); alu_in = 16'($urandom);
        pushes++;
      end
      @(negedge clk);
      checks++;
      if (level !== 4'd8 || drop_cnt !== 8'd4) begin
        errors++;
        $display("FAIL full_pushpop: level=%0d drops=%0d, required 8 4", level, drop_cnt);
      end
    end
    step();
    wait_drain(100);
    checks++;
    if (pushes == 0 || seen.size() != 2 * (8 + pushes)) begin
      errors++;
      $display("FAIL full_pushpop_count: beats=%0d pushes=%0d, required %0d", seen.size(), pushes, 2 * (8 + pushes));
    end
  endtask

  task automatic test_stall();
    logic [15:0] pcs [5];
    logic [15:0] alus [5];
    bit pat [4];
    bit done;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    done = 0;
    seen.delete();
    tr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      pcs[i] = 16'h0300 + 16'(i); alus[i] = 16'($urandom);
      pc_in = pcs[i]; alu_in = alus[i];
    end
    for (int c = 0; c < 100; c++) begin
      step();
      tr_ready = pat[c % 4];
      if (mq.size() == 0 && tr_valid === 1'b0) begin
        done = 1;
        break;
      end
    end
    tr_ready = 1;
    checks++;
    if (!done || seen.size() != 10) begin
      errors++;
      $display("FAIL stall_count: beats=%0d done=%b, required 10 beats", seen.size(), done);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[2*i] !== pcs[i] || seen[2*i+1] !== alus[i]) begin
          errors++;
          $display("FAIL stall_entry%0d: %h %h, required %h %h", i, seen[2*i], seen[2*i+1], pcs[i], alus[i]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    tr_ready = 0;
    for (int i = 0; i < 308; i++) begin
      step();
      pc_in = 16'h0400 + 16'(i); alu_in = 16'($urandom);
    end
    step();
    @(negedge clk);
    checks++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1 || level !== 4'd8) begin
      errors++;
      $display("FAIL saturate: drops=%0d ovf=%b level=%0d, required 255 1 8", drop_cnt, overflow, level);
    end
  endtask

  task automatic test_rearm();
    seen.delete();
    step();
    arm = 0; tr_ready = 1;
    for (int c = 0; c < 40; c++) begin
      step();
      pc_in = pc_in + 16'h0001;
    end
    @(negedge clk);
    checks++;
    if (seen.size() != 16 || overflow !== 1'b1 || drop_cnt !== 8'd255 || level !== 4'd0) begin
      errors++;
      $display("FAIL disarm_drain: beats=%0d ovf=%b drops=%0d level=%0d, required 16 1 255 0",
               seen.size(), overflow, drop_cnt, level);
    end
    step();
    arm = 1;
    step();
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0 || level !== 4'd1) begin
      errors++;
      $display("FAIL rearm_clear: ovf=%b drops=%0d level=%0d, required 0 0 1", overflow, drop_cnt, level);
    end
    wait_drain(50);
  endtask

  task automatic test_reset_mid();
    logic [15:0] a0;
    seen.delete();
    tr_ready = 0;
    step();
    pc_in = 16'h0ABC; alu_in = 16'($urandom);
    step();
    step();
    tr_ready = 1;
    step();
    tr_ready = 0;
    @(negedge clk);
    checks++;
    if (tr_valid !== 1'b1 || tr_last !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_send_alu: valid=%b last=%b, required 1 1", tr_valid, tr_last);
    end
    #3;
    reset = 0;
    #1;
    checks++;
    if (tr_valid !== 0 || tr_last !== 0 || tr_data !== 0 || level !== 0 || overflow !== 0) begin
      errors++;
      $display("FAIL async_reset: valid=%b last=%b data=%h level=%0d ovf=%b, required all 0",
               tr_valid, tr_last, tr_data, level, overflow);
    end
    step();
    step();
    reset = 1; arm = 0; pc_in = 16'h0777; a0 = 16'($urandom); alu_in = a0;
    step();
    step();
    arm = 1;
    step();
    @(negedge clk);
    checks++;
    if (level !== 4'd1 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rearm_first_sample: level=%0d ovf=%b drops=%0d, required 1 0 0", level, overflow, drop_cnt);
    end
    seen.delete();
    tr_ready = 1;
    step();
    wait_drain(50);
    checks++;
    if (seen.size() != 2 || seen[0] !== 16'h0777 || seen[1] !== a0) begin
      errors++;
      $display("FAIL post_reset_entry: beats=%0d, required 0777 %h", seen.size(), a0);
    end
  endtask

  initial begin
    reset = 1'b1;
    #2 reset = 1'b0;
    test_reset();
    test_hold_pc();
    test_overflow();
    test_full_pushpop();
    test_stall();
    test_saturate();
    test_rearm();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
